// File: rtl/ex_mem_buf.sv
// EX/MEM skid buffer: 2-entry FIFO between the EX and MEM stages, with registered ready/valid.
// Optional macro EX_MEM_OVF_TRAP_EN turns signed overflow into a trap entry with its side effects suppressed.

module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module ex_mem_buf #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_zout,
  input  logic              alu_nout,
  input  logic              alu_vout,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_ovf_chk,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [DATA_W-1:0] out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_z,
  output logic              out_n,
  output logic              out_v,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_ovf_trap
);
  localparam int NUM_SLOTS = 2;
  localparam int ENT_W     = 2*DATA_W + RD_W + 7;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
    logic              z;
    logic              n;
    logic              v;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              ovf_trap;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  logic   wptr_q, wptr_d, rptr_q, rptr_d;
  logic   push, pop;
  logic   trap;
  ent_t   ent_in, head;
  logic [NUM_SLOTS-1:0][ENT_W-1:0] slot_q;

  // Handshake outputs decode from registered state only.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    push    = in_valid && in_ready && !flush;
    pop     = out_valid && out_ready && !flush;
    if (flush) begin
      state_d = EMPTY;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef EX_MEM_OVF_TRAP_EN
  assign trap = in_ovf_chk && alu_vout;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    ent_in          = '0;
    ent_in.sum      = alu_sum;
    ent_in.wdata    = in_wdata;
    ent_in.rd       = in_rd;
    ent_in.z        = alu_zout;
    ent_in.n        = alu_nout;
    ent_in.v        = alu_vout;
    ent_in.regwrite = in_regwrite && !trap;
    ent_in.memread  = in_memread  && !trap;
    ent_in.memwrite = in_memwrite && !trap;
    ent_in.ovf_trap = trap;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
      ex_mem_slot #(.W(ENT_W)) u_slot (
        .clk   (clk),
        .reset (reset),
        .we    (push && (wptr_q == 1'(i))),
        .d     (ent_in),
        .q     (slot_q[i])
      );
    end
  endgenerate

  assign head         = ent_t'(slot_q[rptr_q]);
  assign out_sum      = head.sum;
  assign out_wdata    = head.wdata;
  assign out_rd       = head.rd;
  assign out_z        = head.z;
  assign out_n        = head.n;
  assign out_v        = head.v;
  assign out_regwrite = head.regwrite;
  assign out_memread  = head.memread;
  assign out_memwrite = head.memwrite;

`ifdef EX_MEM_OVF_TRAP_EN
  assign out_ovf_trap = head.ovf_trap;
`else
  // Overflow check has no effect in this build; the trap port stays low.
  logic unused_ovf;
  assign unused_ovf   = ^{in_ovf_chk, head.ovf_trap};
  assign out_ovf_trap = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
// Bench for ex_mem_buf: directed scenarios then random traffic against a queue-based model.
module tb_ex_mem_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] alu_sum, in_wdata;
  logic        alu_zout, alu_nout, alu_vout;
  logic [4:0]  in_rd;
  logic        in_regwrite, in_memread, in_memwrite, in_ovf_chk;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_sum, out_wdata;
  logic [4:0]  out_rd;
  logic        out_z, out_n, out_v, out_regwrite, out_memread, out_memwrite, out_ovf_trap;

  ex_mem_buf #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_nout(alu_nout), .alu_vout(alu_vout),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_wdata(in_wdata), .in_ovf_chk(in_ovf_chk),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_z(out_z), .out_n(out_n), .out_v(out_v), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite), .out_ovf_trap(out_ovf_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum, wdata;
    logic [4:0]  rd;
    logic        z, n, v, rw, mr, mw, trap;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk();
    ent_t e;
    logic t;
`ifdef EX_MEM_OVF_TRAP_EN
    t = in_ovf_chk & alu_vout;
`else
    t = 1'b0;
`endif
    e.sum = alu_sum; e.wdata = in_wdata; e.rd = in_rd;
    e.z = alu_zout; e.n = alu_nout; e.v = alu_vout;
    e.rw = in_regwrite & ~t; e.mr = in_memread & ~t; e.mw = in_memwrite & ~t;
    e.trap = t;
    return e;
  endfunction

  task automatic check_all(input string tag);
    ent_t e;
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() != 0));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
    if (q.size() != 0) begin
      e = q[0];
      chk({tag, ".head"},
          128'({out_sum, out_wdata, out_rd, out_z, out_n, out_v,
                out_regwrite, out_memread, out_memwrite, out_ovf_trap}),
          128'({e.sum, e.wdata, e.rd, e.z, e.n, e.v, e.rw, e.mr, e.mw, e.trap}));
    end
  endtask

  // One clock: model updates from pre-edge inputs, outputs sampled on the falling edge.
  task automatic step(input string tag);
    bit can_push;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      can_push = (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (can_push && in_valid) q.push_back(mk());
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic [4:0] rd,
                       input logic rw, input logic ovf, input logic vo,
                       input logic ordy, input logic fl);
    in_valid = v; alu_sum = s; in_rd = rd; in_regwrite = rw;
    in_ovf_chk = ovf; alu_vout = vo; out_ready = ordy; flush = fl;
    in_wdata = $urandom; alu_zout = 1'($urandom); alu_nout = 1'($urandom);
    in_memread = 1'($urandom); in_memwrite = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(1));
    chk({tag, ".fields"},
        128'({out_sum, out_wdata, out_rd, out_z, out_n, out_v,
              out_regwrite, out_memread, out_memwrite, out_ovf_trap}), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset_release");

    // single push, 1-cycle latency
    drive(1, 32'h5, 5'd3, 1, 0, 0, 0, 0);
    step("push1");
    chk("push1.sum", 128'(out_sum), 128'h5);
    chk("push1.rd",  128'(out_rd),  128'd3);
    chk("push1.rw",  128'(out_regwrite), 128'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step("drain1");

    // fill, overflow ignored, drain in order
    drive(1, 32'h11, 5'd1, 1, 0, 0, 0, 0); step("fill_a");
    drive(1, 32'h22, 5'd2, 1, 0, 0, 0, 0); step("fill_b");
    chk("full.in_ready", 128'(in_ready), 128'd0);
    drive(1, 32'h33, 5'd3, 1, 0, 0, 0, 0); step("full_ignore");
    chk("full.hold", 128'(out_sum), 128'h11);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step("pop_a");
    chk("pop_a.sum", 128'(out_sum), 128'h22);
    step("pop_b");
    chk("pop_b.valid", 128'(out_valid), 128'd0);
    step("pop_empty");

    // simultaneous push and pop in ONE
    drive(1, 32'hA, 5'd4, 1, 0, 0, 0, 0); step("one_a");
    drive(1, 32'hB, 5'd5, 1, 0, 0, 1, 0); step("pushpop");
    chk("pushpop.sum", 128'(out_sum), 128'hB);

    // flush from FULL with a concurrent push
    drive(1, 32'hC, 5'd6, 1, 0, 0, 0, 0); step("fill_c");
    chk("fill_c.full", 128'(in_ready), 128'd0);
    drive(1, 32'hD, 5'd7, 1, 0, 0, 1, 1); step("flush");
    chk("flush.valid", 128'(out_valid), 128'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step("post_flush");

    // overflow trap entry
    drive(1, 32'h8000_0000, 5'd9, 1, 1, 1, 0, 0); step("ovf");
`ifdef EX_MEM_OVF_TRAP_EN
    chk("ovf.trap", 128'(out_ovf_trap), 128'd1);
    chk("ovf.rw",   128'(out_regwrite), 128'd0);
`else
    chk("ovf.trap", 128'(out_ovf_trap), 128'd0);
    chk("ovf.rw",   128'(out_regwrite), 128'd1);
`endif
    drive(1, 32'h1234, 5'd10, 1, 0, 0, 0, 0); step("fill_ovf");

    // asynchronous reset mid-cycle while FULL
    drive(1, 32'hEE, 5'd11, 1, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    q.delete();
    check_reset_outputs("reset_mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    drive(1, 32'h77, 5'd12, 1, 0, 0, 0, 0); step("after_reset");
    chk("after_reset.sum", 128'(out_sum), 128'h77);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_buf.md
EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU result and store data.
REQ-002 SHALL have parameter RD_W, default 5, width of destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream EX stage presents a result.
REQ-006 SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 SHALL have port alu_sum  input  DATA_W  ALU result.
REQ-008 SHALL have ports alu_zout, alu_nout, alu_vout  input  1 each  ALU zero, negative, overflow flags.
REQ-009 SHALL have port in_rd  input  RD_W  destination register index.
REQ-010 SHALL have ports in_regwrite, in_memread, in_memwrite  input  1 each  MEM/WB controls.
REQ-011 SHALL have port in_wdata  input  DATA_W  store data for memory.
REQ-012 SHALL have port in_ovf_chk  input  1  instruction is signed add/sub, overflow is meaningful.
REQ-013 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-014 SHALL have port out_valid  output  1  head entry is valid.
REQ-015 SHALL have port out_ready  input  1  MEM stage consumes head this cycle.
REQ-016 SHALL have ports out_sum, out_wdata  output  DATA_W; out_rd  output  RD_W; out_z, out_n, out_v, out_regwrite, out_memread, out_memwrite, out_ovf_trap  output  1 each  head entry fields.

Function
REQ-017 SHALL implement a 2-entry FIFO with states EMPTY, ONE, FULL; 1-bit write/read pointers wrap 1->0.
REQ-018 SHALL push on rising edge when in_valid && in_ready, storing all in_* and alu_* fields as one entry.
REQ-019 SHALL pop on rising edge when out_valid && out_ready, advancing read pointer.
REQ-020 SHALL drive in_ready = 1 iff state != FULL, decoded from registered state only (no combinational path from out_ready).
REQ-021 SHALL drive out_valid = 1 iff state != EMPTY; out_* fields come from the entry at read pointer.
REQ-022 SHALL give latency of one cycle: entry pushed at edge N is on out_* with out_valid=1 in the cycle after edge N when buffer was EMPTY.
REQ-023 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop, with head becoming the new entry; FULL->ONE on pop.
REQ-024 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-025 SHALL ignore in_valid when FULL (no overwrite) and ignore out_ready when EMPTY (no underflow).
REQ-026 SHALL on flush=1 go to EMPTY at next edge, resetting both pointers to 0; a push or pop in the same cycle is discarded; flush overrides all other events.
REQ-027 SHALL pass flags and alu_sum unmodified (no recomputation of zero/negative).

Reset
REQ-028 SHALL on reset=1 immediately (asynchronously) force state EMPTY, pointers 0, out_valid=0, in_ready=1.
REQ-029 SHALL clear storage on reset so out_sum, out_wdata, out_rd and all 1-bit out_* read 0 after reset.
REQ-030 SHALL discard any entry in flight when reset asserts mid-operation; first push after reset release behaves as from EMPTY.

Configuration
REQ-031 SHALL, when macro EX_MEM_OVF_TRAP_EN is defined, store entries with in_ovf_chk && alu_vout with regwrite, memread and memwrite forced to 0 and out_ovf_trap=1 for that entry.
REQ-032 SHALL, when EX_MEM_OVF_TRAP_EN is undefined, keep port out_ovf_trap tied to 0 and pass controls unmodified regardless of alu_vout.

Verification
REQ-033 SHALL cover: reset, then push alu_sum=0x00000005, in_rd=3, in_regwrite=1 with out_ready=0 -> next cycle out_valid=1, out_sum=0x00000005, out_rd=3, in_ready=1.
REQ-034 SHALL cover: two pushes (0x11, 0x22) with out_ready=0 -> in_ready=0; third push of 0x33 ignored; then out_ready=1 for two cycles -> out_sum 0x11 then 0x22, then out_valid=0.
REQ-035 SHALL cover: state ONE holding 0xA, simultaneous push 0xB and pop -> next cycle out_sum=0xB, out_valid=1, in_ready=1.
REQ-036 SHALL cover: FULL buffer, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed push absent.
REQ-037 SHALL cover: push alu_sum=0x80000000, alu_vout=1, in_ovf_chk=1, in_regwrite=1 -> with EX_MEM_OVF_TRAP_EN out_ovf_trap=1, out_regwrite=0; without, out_ovf_trap=0, out_regwrite=1.
REQ-038 SHALL cover: reset asserted asynchronously between edges while FULL -> out_valid=0 and out_sum=0 before next clock edge.
